// File: rtl/niosii_sys_lcd_bus_seq_if.sv
// Avalon-MM slave bundle between the Nios II data master and the LCD bus sequencer.
interface niosii_sys_lcd_bus_seq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output read_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  read_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/niosii_sys_lcd_bus_seq.sv
// HD44780 character-LCD bus sequencer: every accepted CPU write becomes one fully
// timed RS/RW/E bus cycle; LCD read results come back through a status register.
module niosii_sys_lcd_bus_seq #(
  parameter int unsigned T_AS  = 3,
  parameter int unsigned T_PW  = 12,
  parameter int unsigned T_H   = 2,
  parameter int unsigned T_GAP = 10
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  niosii_sys_lcd_bus_seq_if.slave  avs,
  inout  wire  [7:0]               lcd_data_io,
  output logic                     lcd_rs_o,
  output logic                     lcd_rw_o,
  output logic                     lcd_en_o
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [CNT_W-1:0] LD_AS  = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] LD_PW  = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LD_H   = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] LD_GAP = CNT_W'(T_GAP - 1);

  function automatic logic [31:0] status_word(input logic       ov,
                                              input logic       bsy,
                                              input logic       rv,
                                              input logic [7:0] data);
    status_word = {21'd0, ov, bsy, rv, data};
  endfunction

  logic [2:0]       state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             rs_q,       rs_d;
  logic             rw_q,       rw_d;
  logic             en_q,       en_d;
  logic             drive_q,    drive_d;
  logic [7:0]       byte_q,     byte_d;
  logic [7:0]       rd_data_q,  rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overrun_q,  overrun_d;
  logic [31:0]      readdata_q, readdata_d;

  logic busy_s;
  logic cnt_zero_s;
  logic wr_req_s;
  logic accept_s;
  logic drop_s;
  logic stat_rd_s;
  logic op_rs_s;
  logic op_rw_s;
  logic rd_capture_s;
  logic unused_wdata_s;

  assign busy_s         = (state_q != ST_IDLE);
  assign cnt_zero_s     = (cnt_q == {CNT_W{1'b0}});
  assign wr_req_s       = avs.chipselect & ~avs.write_n & (avs.address != 2'd3);
  assign accept_s       = wr_req_s & ~busy_s;
  assign drop_s         = wr_req_s & busy_s;
  assign stat_rd_s      = avs.chipselect & ~avs.read_n & (avs.address == 2'd3);
  assign rd_capture_s   = (state_q == ST_PULSE) & cnt_zero_s & rw_q;
  assign unused_wdata_s = ^avs.writedata[31:8];

  // Register-select and direction implied by the write address.
  always_comb begin
    op_rs_s = 1'b0;
    op_rw_s = 1'b0;
    case (avs.address)
      2'd0: begin
        op_rs_s = 1'b1;
        op_rw_s = 1'b0;
      end
      2'd1: begin
        op_rs_s = 1'b0;
        op_rw_s = 1'b0;
      end
      2'd2: begin
        op_rs_s = avs.writedata[0];
        op_rw_s = 1'b1;
      end
      default: begin
        op_rs_s = 1'b0;
        op_rw_s = 1'b0;
      end
    endcase
  end

  // Bus-cycle sequencer: each phase loads its length minus one and advances on zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    en_d    = en_q;
    drive_d = drive_q;
    byte_d  = byte_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SETUP;
          cnt_d   = LD_AS;
          rs_d    = op_rs_s;
          rw_d    = op_rw_s;
          byte_d  = avs.writedata[7:0];
          drive_d = ~op_rw_s;
          en_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_zero_s) begin
          state_d = ST_PULSE;
          cnt_d   = LD_PW;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_PULSE: begin
        if (cnt_zero_s) begin
          state_d = ST_HOLD;
          cnt_d   = LD_H;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HOLD: begin
        if (cnt_zero_s) begin
          state_d = ST_GAP;
          cnt_d   = LD_GAP;
          drive_d = 1'b0;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_GAP: begin
        if (cnt_zero_s) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        en_d    = 1'b0;
        drive_d = 1'b0;
      end
    endcase
  end

  // Status flags: a set in the same cycle as a status-read clear takes priority.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_capture_s) begin
      rd_data_d = lcd_data_io;
    end else begin
      rd_data_d = rd_data_q;
    end

    rd_valid_d = rd_valid_q;
    if (rd_capture_s) begin
      rd_valid_d = 1'b1;
    end else if (accept_s && op_rw_s) begin
      rd_valid_d = 1'b0;
    end else if (stat_rd_s) begin
      rd_valid_d = 1'b0;
    end else begin
      rd_valid_d = rd_valid_q;
    end

    overrun_d = overrun_q;
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (stat_rd_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    readdata_d = 32'd0;
    if (avs.address == 2'd3) begin
      readdata_d = status_word(overrun_q, busy_s, rd_valid_q, rd_data_q);
    end else begin
      readdata_d = 32'd0;
    end
  end

  // State and output registers; reset drops E and releases the bus on the next edge.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      en_q       <= 1'b0;
      drive_q    <= 1'b0;
      byte_q     <= 8'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      en_q       <= en_d;
      drive_q    <= drive_d;
      byte_q     <= byte_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign lcd_rs_o     = rs_q;
  assign lcd_rw_o     = rw_q;
  assign lcd_en_o     = en_q;
  assign lcd_data_io  = drive_q ? byte_q : {8{1'bz}};

endmodule
